uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver and upstream of the AXI read path. It captures each single-cycle received-byte pulse into a DEPTH-entry circular FIFO and presents bytes to the consumer over a valid/ready handshake. It also reports occupancy, a programmable high-water flag and a sticky overflow flag for drops caused by a full buffer.

## Interface
- DATA_BITS, 8: width of each received byte; matches the receiver's data width.
- DEPTH, 16: number of entries; must be a power of two and ≥ 2.
- THRESH, 8: high-water level; range 1..DEPTH.
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  DATA_BITS  byte from receiver; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle pulse from receiver: new byte, parity OK.
- m_data  out  DATA_BITS  head-of-FIFO byte; defined only when m_valid=1.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- level  out  1  count ≥ THRESH.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- ovf_clear  in  1  one-cycle pulse: clear overflow.
- flush  in  1  one-cycle pulse: discard all stored bytes.

## Operation
- Storage: DEPTH×DATA_BITS register array. Write pointer wr_ptr and read pointer rd_ptr are each $clog2(DEPTH) bits and wrap modulo DEPTH with no special case. count is a separate register.
- push = rx_valid & (!full | pop). pop = m_valid & m_ready.
- On push: mem[wr_ptr] ← rx_data, and wr_ptr increments.
- On pop: rd_ptr increments.
- count update: push only → count+1; pop only → count−1; push and pop together → count unchanged.
- Full with simultaneous pop: the push is accepted. The slot freed in the same cycle is reused, count stays DEPTH, and no overflow occurs.
- Drop: rx_valid & full & !pop. The byte is discarded, FIFO state does not change, and overflow is set to 1 in the next cycle.
- overflow: set by a drop, cleared by ovf_clear. A drop in the same cycle as ovf_clear wins (overflow stays 1). flush does not affect overflow.
- flush has priority over push and pop in the same cycle. wr_ptr, rd_ptr and count go to 0; the concurrent rx_valid byte is discarded without setting overflow; the concurrent pop is ignored.
- m_data = mem[rd_ptr], read combinationally (first-word fall-through).
- m_valid = !empty.
- empty, full and level are decoded from the count register.
- Pop while empty is impossible because m_valid gates it. m_ready is don't-care when m_valid=0.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, overflow=0, so m_valid=0, empty=1, full=0, level=0. Memory contents are not reset. m_data is X-tolerant while m_valid=0.

## Timing
- Latency: a byte pushed at edge N appears on m_data with m_valid=1 after edge N, i.e. in cycle N+1. This holds even when the FIFO was empty.
- Pop takes effect at the edge where m_valid & m_ready=1. The next byte (or m_valid=0) is visible in the following cycle.
- Back-to-back pops at one per cycle are supported. Back-to-back rx_valid pulses at one per cycle are supported, although the receiver produces at most one per frame.
- count, empty, full, level and overflow are registered or decoded from registers; no combinational path runs from rx_valid to them.
- The only combinational input-to-output dependency is from the rd_ptr register to m_data. There is no path from m_ready to any output in the same cycle.
- rst asserted mid-stream: at the next edge all state returns to reset values regardless of rx_valid, m_ready or flush.

## Test plan
- Reset then single byte: rst 2 cycles, rx_valid pulse with 0xA5, m_ready=0 → next cycle m_valid=1, m_data=0xA5, count=1, empty=0. Then m_ready=1 for 1 cycle → m_valid=0, count=0.
- Fill and wrap: DEPTH=16, push 0x00..0x0F → full=1, count=16, level asserted from count=8. Pop 4, push 0x10..0x13 → pops return 0x04..0x13 in order across the pointer wrap.
- Overflow: with full, pulse rx_valid=0x55, m_ready=0 → count stays 16, overflow=1 next cycle, byte 0x55 never appears. ovf_clear → overflow=0. Drop and ovf_clear in the same cycle → overflow=1.
- Full plus simultaneous push/pop: FIFO full with head 0x00; in one cycle rx_valid=0x77 and m_ready=1 → count=16, overflow=0, 0x77 is the last byte popped.
- Flush priority: count=5, one cycle with flush, rx_valid=0x3C and m_ready=1 → next cycle count=0, m_valid=0, overflow unchanged. The next push of 0x11 reads back as 0x11.
- Reset mid-operation: count=9 and overflow=1, assert rst for one cycle during an rx_valid pulse → count=0, empty=1, level=0, overflow=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte handshake from the UART receiver through the FIFO to the consumer
interface uart_rx_fifo_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic [DATA_BITS-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;
   modport master (output rx_data, rx_valid, m_ready, input m_data, m_valid);
   modport slave (input rx_data, rx_valid, m_ready, output m_data, m_valid);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through buffer for received bytes with occupancy and overflow flags
module uart_rx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH = 16,
   parameter int THRESH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   uart_rx_fifo_if.slave bus,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          level,
   output logic          overflow,
   input  logic          ovf_clear,
   input  logic          flush
);
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic pop, push, drop;
   assign empty = count == '0;
   assign full = count == CW'(DEPTH);
   assign level = count >= CW'(THRESH);
   assign bus.m_valid = !empty;
   assign bus.m_data = mem[rd_ptr];
   assign pop = bus.m_valid & bus.m_ready;
   // a full FIFO still accepts a byte when the head leaves in the same cycle
   assign push = bus.rx_valid & (!full | pop);
   // a flushed byte is discarded on purpose, so it never counts as a drop
   assign drop = bus.rx_valid & full & !pop & !flush;
   // byte storage, deliberately left unreset
   always_ff @(posedge clk)
      if (push & !flush) mem[wr_ptr] <= bus.rx_data;
   // pointers, occupancy and sticky overflow; flush outranks push and pop
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= drop | (overflow & !ovf_clear);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
endmodule
